// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC generation, credit-limited in-order imem requests,
// instruction FIFO toward decode, redirect flush. Optional misaligned-target halt: FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  output logic        fetch_misaligned
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [31:0]   r_req_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [31:0]   r_fifo_inst [FIFO_DEPTH];
  logic [31:0]   r_fifo_pc   [FIFO_DEPTH];

  logic [31:0]   w_target;
  logic          w_halted;
  logic          w_credit;
  logic          w_req_fire;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic [CW-1:0] w_out_next;

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid never
  // depends on ready. Responses have no ready and are always consumed (pushed or dropped).
  assign w_target   = {redirect_pc[31:2], 2'b00};
  assign w_credit   = ({1'b0, r_outstanding} + {1'b0, r_count}) < (CW+1)'(FIFO_DEPTH);
  assign imem_req_valid = !rst && !redirect_valid && !w_halted && w_credit;
  assign imem_req_addr  = r_req_pc;
  assign w_req_fire = imem_req_valid && imem_req_ready;
  assign w_drop     = imem_rsp_valid && (r_drop_cnt != '0);
  assign w_push     = imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid && !w_halted;
  assign w_pop      = inst_valid && inst_ready;
  assign w_out_next = r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);

  assign inst_valid  = (r_count != '0);
  assign instruction = r_fifo_inst[r_rd_ptr];
  assign inst_pc     = r_fifo_pc[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_pc      <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      if (w_req_fire) r_req_pc <= r_req_pc + 32'd4;
      r_outstanding <= w_out_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
        r_rsp_pc <= r_rsp_pc + 32'd4;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
      // Flush wins over any push/pop this cycle; everything still in flight becomes stale.
      if (redirect_valid) begin
        r_req_pc   <= w_target;
        r_rsp_pc   <= w_target;
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_drop_cnt <= w_out_next;
      end
    end
  end

  // Storage needs no reset: entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_inst[r_wr_ptr] <= imem_rsp_data;
      r_fifo_pc[r_wr_ptr]   <= r_rsp_pc;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_halted;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_halted <= 1'b0;
    end else if (redirect_valid) begin
      r_halted <= |redirect_pc[1:0];
    end
  end

  assign w_halted         = r_halted;
  assign fetch_misaligned = r_halted;
`else
  logic w_unused_pc_lsbs;

  assign w_unused_pc_lsbs = ^redirect_pc[1:0];
  assign w_halted         = 1'b0;
  assign fetch_misaligned = 1'b0;
`endif

endmodule
